// File: rtl/pc_branch_unit.sv
// pc_branch_unit: fetch PC register with branch/jump redirect, one-cycle flush and saturating taken-branch count
module pc_branch_unit #(
  parameter int ADDR_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] PC_STEP = ADDR_W'(1),
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branchValid,
  input  logic              branchIdea,
  input  logic [ADDR_W-1:0] branchPc,
  input  logic [ADDR_W-1:0] branchOffset,
  input  logic              jumpValid,
  input  logic [ADDR_W-1:0] jumpTarget,
  input  logic              halt,
  output logic [ADDR_W-1:0] pc,
  output logic              fetchValid,
  output logic              flush,
  output logic [CNT_W-1:0]  takenCount
);
  typedef enum logic [1:0] {START, RUN, FLUSH, HALTED} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] pc_n;
  logic fv_n, fl_n;
  logic [CNT_W-1:0] cnt_n;
  logic taken;
  assign taken = branchValid & branchIdea;
  always_comb begin
    state_n = state;
    pc_n = pc;
    fv_n = fetchValid;
    fl_n = 1'b0;
    cnt_n = takenCount;
    case (state)
      START: begin
        state_n = RUN;
        fv_n = 1'b1;
      end
      RUN:
        if (halt) begin
          state_n = HALTED;
          fv_n = 1'b0;
          fl_n = 1'b1;
        end else if (jumpValid || taken) begin
          // jump outranks a taken branch; only the branch bumps the counter
          state_n = FLUSH;
          pc_n = jumpValid ? jumpTarget : branchPc + branchOffset;
          fv_n = 1'b0;
          fl_n = 1'b1;
          cnt_n = (jumpValid || &takenCount) ? takenCount : takenCount + 1'b1;
        end else if (!stall) begin
          pc_n = pc + PC_STEP;
          fv_n = 1'b1;
        end
      FLUSH: begin
        state_n = stall ? FLUSH : RUN;
        fv_n = !stall;
      end
      default: fv_n = 1'b0;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= START;
      pc <= RESET_PC;
      fetchValid <= 1'b0;
      flush <= 1'b0;
      takenCount <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      fetchValid <= fv_n;
      flush <= fl_n;
      takenCount <= cnt_n;
    end
endmodule

// File: tb/tb_pc_branch_unit.sv
// tb_pc_branch_unit: directed plan plus randomized traffic against a behavioural model, checked every cycle
module tb_pc_branch_unit;
  logic clk = 0, reset = 1, stall = 0, branchValid = 0, branchIdea = 0, jumpValid = 0, halt = 0;
  logic [15:0] branchPc = 0, branchOffset = 0, jumpTarget = 0;
  logic [15:0] pc, pc2;
  logic fetchValid, flush, fv2, fl2;
  logic [15:0] takenCount;
  logic [1:0] tc2;
  int n_cmp = 0, n_bad = 0;

  pc_branch_unit dut (.clk(clk), .reset(reset), .stall(stall), .branchValid(branchValid),
    .branchIdea(branchIdea), .branchPc(branchPc), .branchOffset(branchOffset),
    .jumpValid(jumpValid), .jumpTarget(jumpTarget), .halt(halt), .pc(pc),
    .fetchValid(fetchValid), .flush(flush), .takenCount(takenCount));
  pc_branch_unit #(.CNT_W(2)) dut2 (.clk(clk), .reset(reset), .stall(stall), .branchValid(branchValid),
    .branchIdea(branchIdea), .branchPc(branchPc), .branchOffset(branchOffset),
    .jumpValid(jumpValid), .jumpTarget(jumpTarget), .halt(halt), .pc(pc2),
    .fetchValid(fv2), .flush(fl2), .takenCount(tc2));

  always #5 clk = ~clk;

  // behavioural model: phase flags rather than a state encoding, integer arithmetic with explicit wrap
  int m_pc = 0, m_cnt = 0, m_cnt2 = 0;
  bit m_fv = 0, m_fl = 0, started = 0, halted = 0, pending = 0;
  always @(posedge clk or posedge reset)
    if (reset) begin
      m_pc = 0; m_cnt = 0; m_cnt2 = 0; m_fv = 0; m_fl = 0;
      started = 0; halted = 0; pending = 0;
    end else begin
      m_fl = 0;
      if (!started) begin
        started = 1; m_fv = 1;
      end else if (halted) m_fv = 0;
      else if (pending) begin
        m_fv = !stall;
        pending = stall;
      end else if (halt) begin
        halted = 1; m_fv = 0; m_fl = 1;
      end else if (jumpValid) begin
        m_pc = jumpTarget; m_fv = 0; m_fl = 1; pending = 1;
      end else if (branchValid && branchIdea) begin
        m_pc = (int'(branchPc) + int'(branchOffset)) % 65536;
        m_fv = 0; m_fl = 1; pending = 1;
        m_cnt = (m_cnt == 65535) ? m_cnt : m_cnt + 1;
        m_cnt2 = (m_cnt2 == 3) ? m_cnt2 : m_cnt2 + 1;
      end else if (!stall) begin
        m_pc = (m_pc + 1) % 65536; m_fv = 1;
      end
    end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("m_pc", int'(pc), m_pc);
    chk("m_fetchValid", int'(fetchValid), int'(m_fv));
    chk("m_flush", int'(flush), int'(m_fl));
    chk("m_takenCount", int'(takenCount), m_cnt);
    chk("m_takenCount2", int'(tc2), m_cnt2);
  end

  task automatic step(); @(negedge clk); endtask
  task automatic idle();
    stall = 0; branchValid = 0; branchIdea = 0; jumpValid = 0; halt = 0;
  endtask
  task automatic go(input logic [15:0] t);
    idle(); jumpValid = 1; jumpTarget = t; step(); idle(); step();
  endtask
  task automatic br(input logic [15:0] p, input logic [15:0] o);
    branchValid = 1; branchIdea = 1; branchPc = p; branchOffset = o;
  endtask

  initial begin
    idle();
    repeat (2) step();
    reset = 0;
    step();
    chk("t1_pc0", pc, 16'h0000); chk("t1_fv", fetchValid, 1);
    for (int i = 1; i <= 3; i++) begin
      step(); chk("t1_pc_seq", pc, i); chk("t1_flush", flush, 0); chk("t1_cnt", takenCount, 0);
    end
    go(16'h0005);
    chk("t2_start_pc", pc, 5);
    br(16'h0004, 16'hFFFE); step(); idle();
    chk("t2_pc", pc, 2); chk("t2_flush", flush, 1); chk("t2_fv", fetchValid, 0); chk("t2_cnt", takenCount, 1);
    step();
    chk("t2_pc2", pc, 2); chk("t2_fv2", fetchValid, 1); chk("t2_flush2", flush, 0);
    go(16'h0010);
    branchValid = 1; branchIdea = 0; step(); idle();
    chk("t3_pc", pc, 16'h0011); chk("t3_flush", flush, 0); chk("t3_cnt", takenCount, 1);
    go(16'h0020);
    stall = 1;
    repeat (3) begin
      step(); chk("t4_stall_pc", pc, 16'h0020); chk("t4_stall_fv", fetchValid, 1);
    end
    jumpValid = 1; jumpTarget = 16'h0100; step(); jumpValid = 0;
    chk("t4_jmp_pc", pc, 16'h0100); chk("t4_jmp_flush", flush, 1);
    repeat (2) begin
      step(); chk("t4_flush_stall_fv", fetchValid, 0); chk("t4_flush_stall_pc", pc, 16'h0100);
    end
    stall = 0; step();
    chk("t4_release_fv", fetchValid, 1); chk("t4_release_pc", pc, 16'h0100);
    idle(); jumpValid = 1; jumpTarget = 16'h0040; step(); idle();
    br(16'h0000, 16'h0077); step(); idle();
    chk("t5_ignored_pc", pc, 16'h0040); chk("t5_ignored_cnt", takenCount, 1); chk("t5_ignored_flush", flush, 0);
    go(16'h0030);
    halt = 1; step(); idle();
    chk("t5_halt_pc", pc, 16'h0030); chk("t5_halt_flush", flush, 1);
    repeat (10) begin
      jumpValid = 1'($urandom); br(16'($urandom), 16'($urandom)); stall = 1'($urandom);
      step();
      chk("t5_halted_pc", pc, 16'h0030); chk("t5_halted_fv", fetchValid, 0); chk("t5_halted_flush", flush, 0);
    end
    idle();
    #2 reset = 1;
    #1 chk("t5_async_pc", pc, 0); chk("t5_async_fv", fetchValid, 0); chk("t5_async_cnt", takenCount, 0);
    step(); reset = 0; step();
    go(16'hFFFF);
    chk("t6_pc_ffff", pc, 16'hFFFF);
    step(); chk("t6_wrap", pc, 0);
    for (int i = 1; i <= 4; i++) begin
      br(16'hFFFE, 16'h0004); step(); idle();
      chk("t6_sat_cnt2", tc2, i > 3 ? 3 : i); chk("t6_cnt16", takenCount, i); chk("t6_wrap_target", pc, 2);
      step();
    end
    for (int i = 0; i < 3000; i++) begin
      stall = ($urandom_range(3) == 0);
      branchValid = 1'($urandom); branchIdea = 1'($urandom);
      branchPc = 16'($urandom); branchOffset = 16'($urandom);
      jumpValid = ($urandom_range(7) == 0); jumpTarget = 16'($urandom);
      halt = ($urandom_range(99) == 0);
      reset = ($urandom_range(149) == 0);
      step();
    end
    idle(); reset = 0; step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
